// File: rtl/div_result_bcd_if.sv
// div_result_bcd_if: handshake bundle between the divider, the BCD converter
// and the display/readout consumer.
//   slave  - the converter side (takes in_*, drives out_*)
//   master - the surrounding logic (drives in_*, takes out_*)
interface div_result_bcd_if #(
    parameter int W      = 4,
    parameter int DIGITS = 2
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2*W-1:0]        in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   q_bcd;
    logic [4*DIGITS-1:0]   r_bcd;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, q_bcd, r_bcd
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, q_bcd, r_bcd
    );
endinterface

// File: rtl/div_result_bcd.sv
// div_result_bcd: converts the divider's packed {quotient, remainder} byte to
// two packed BCD fields with a bit-serial double-dabble engine. The quotient is
// converted first, then the remainder; both outputs update on the same edge.
//
// Optional build macro DIV_RESULT_BCD_BLANK_EN: leading zero digits above the
// least significant digit are shown as 4'hF (blank) in q_bcd/r_bcd.
//
// state  | meaning
// IDLE   | waiting for in_valid, in_ready high
// CONV_Q | shifting quotient bits in, MSB first, W cycles
// CONV_R | shifting remainder bits in, MSB first, W cycles
// DONE   | result held on q_bcd/r_bcd, out_valid high until out_ready
module div_result_bcd #(
    parameter int W      = 4,
    parameter int DIGITS = 2
) (
    input  logic              clk,
    input  logic              rst,
    div_result_bcd_if.slave   bus
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(W - 1);

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

    localparam longint unsigned MAX_FIELD = (64'd1 << W) - 64'd1;

    generate
        if (pow10(DIGITS) <= MAX_FIELD) begin : g_digits_too_small
            $fatal(1, "div_result_bcd: DIGITS too small to hold 2^W-1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV_Q = 2'd1,
        CONV_R = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [W-1:0]     r_shift;
    logic [W-1:0]     r_rem;
    logic [BW-1:0]    r_acc;
    logic [BW-1:0]    r_q_res;
    logic [CW-1:0]    r_cnt;
    logic [BW-1:0]    r_q_bcd;
    logic [BW-1:0]    r_r_bcd;

    logic [BW-1:0]    w_adj;
    logic [BW-1:0]    w_acc_next;
    logic             w_cnt_last;
    logic             w_in_ready;
    logic             w_out_valid;

    // Display formatting applied at the moment the outputs are loaded.
    function automatic logic [BW-1:0] fmt_bcd(input logic [BW-1:0] v);
        logic [BW-1:0] res;
`ifdef DIV_RESULT_BCD_BLANK_EN
        logic lead;
`endif
        res = v;
`ifdef DIV_RESULT_BCD_BLANK_EN
        lead = 1'b1;
        for (int d = DIGITS - 1; d > 0; d--) begin
            if (lead && (v[4*d +: 4] == 4'd0)) begin
                res[4*d +: 4] = 4'hF;
            end else begin
                lead = 1'b0;
            end
        end
`endif
        return res;
    endfunction

    assign w_cnt_last = (r_cnt == '0);

    // One double-dabble step: correct every digit >= 5, then shift in the next bit.
    always_comb begin
        w_adj = r_acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (w_adj[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = w_adj[4*d +: 4] + 4'd3;
            end
        end
        w_acc_next = (w_adj << 1) | BW'(r_shift[W-1]);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_next = CONV_Q;
                end
            end
            CONV_Q: begin
                if (w_cnt_last) begin
                    w_state_next = CONV_R;
                end
            end
            CONV_R: begin
                if (w_cnt_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Conversion datapath; the bit counter counts down to a terminal zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_rem   <= '0;
            r_acc   <= '0;
            r_q_res <= '0;
            r_cnt   <= '0;
            r_q_bcd <= '0;
            r_r_bcd <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_shift <= bus.in_data[2*W-1:W];
                        r_rem   <= bus.in_data[W-1:0];
                        r_acc   <= '0;
                        r_cnt   <= CNT_LOAD;
                    end
                end
                CONV_Q: begin
                    if (w_cnt_last) begin
                        r_q_res <= w_acc_next;
                        r_acc   <= '0;
                        r_shift <= r_rem;
                        r_cnt   <= CNT_LOAD;
                    end else begin
                        r_acc   <= w_acc_next;
                        r_shift <= r_shift << 1;
                        r_cnt   <= r_cnt - CW'(1);
                    end
                end
                CONV_R: begin
                    r_acc   <= w_acc_next;
                    r_shift <= r_shift << 1;
                    if (w_cnt_last) begin
                        r_q_bcd <= fmt_bcd(r_q_res);
                        r_r_bcd <= fmt_bcd(w_acc_next);
                    end else begin
                        r_cnt   <= r_cnt - CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.q_bcd     = r_q_bcd;
    assign bus.r_bcd     = r_r_bcd;
endmodule

// File: tb/tb_div_result_bcd.sv
// Bench for div_result_bcd: a cycle-count reference model plus directed and
// random stimulus; a negedge process compares every output on every cycle.
module tb_div_result_bcd;
    localparam int W      = 4;
    localparam int DIGITS = 2;
    localparam int BW     = 4 * DIGITS;
    localparam int LAT    = 2 * W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_result_bcd_if #(.W(W), .DIGITS(DIGITS)) bus ();

    div_result_bcd #(.W(W), .DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Value -> packed BCD display word, straight from decimal arithmetic.
    function automatic logic [BW-1:0] to_bcd(input int v);
        logic [BW-1:0] r;
        int x;
        int ndig;
        r = '0;
        x = v;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
`ifdef DIV_RESULT_BCD_BLANK_EN
        ndig = 1;
        x = v / 10;
        while (x > 0) begin
            ndig++;
            x = x / 10;
        end
        for (int d = ndig; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'hF;
        end
`else
        ndig = 0;
`endif
        return r;
    endfunction

    // Picks the literal expectation for the current build.
    function automatic logic [7:0] lit(input logic [7:0] plain, input logic [7:0] blank);
`ifdef DIV_RESULT_BCD_BLANK_EN
        return (plain & 8'h00) | blank;
`else
        return (blank & 8'h00) | plain;
`endif
    endfunction

    // Reference model: acceptance from idle, result LAT edges later, held until out_ready.
    bit             started   = 1'b0;
    bit             m_pending = 1'b0;
    bit             m_done    = 1'b0;
    int             m_cnt     = 0;
    logic [BW-1:0]  m_q       = '0;
    logic [BW-1:0]  m_r       = '0;
    logic [2*W-1:0] m_data    = '0;

    always @(posedge clk) begin
        if (rst) begin
            started   = 1'b1;
            m_pending = 1'b0;
            m_done    = 1'b0;
            m_cnt     = 0;
            m_q       = '0;
            m_r       = '0;
        end else if (!m_pending) begin
            if (bus.in_valid) begin
                m_pending = 1'b1;
                m_cnt     = 0;
                m_data    = bus.in_data;
            end
        end else if (!m_done) begin
            m_cnt++;
            if (m_cnt == LAT) begin
                m_done = 1'b1;
                m_q    = to_bcd(int'(m_data[2*W-1:W]));
                m_r    = to_bcd(int'(m_data[W-1:0]));
            end
        end else if (bus.out_ready) begin
            m_pending = 1'b0;
            m_done    = 1'b0;
        end
    end

    logic [2*BW-1:0] res_q[$];

    always @(negedge clk) begin
        if (started) begin
            check("cmp_in_ready",  32'(bus.in_ready),  32'(!m_pending));
            check("cmp_out_valid", 32'(bus.out_valid), 32'(m_done));
            check("cmp_q_bcd",     32'(bus.q_bcd),     32'(m_q));
            check("cmp_r_bcd",     32'(bus.r_bcd),     32'(m_r));
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                res_q.push_back({bus.q_bcd, bus.r_bcd});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2*W-1:0] d);
        int t;
        t = 0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && t < 60) begin
            tick();
            t++;
        end
        if (t >= 60) begin
            n_checks++;
            n_fails++;
            $display("FAIL send_timeout: in_ready stayed %b, expected 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 60) begin
            tick();
            cyc++;
        end
        if (cyc >= 60) begin
            n_checks++;
            n_fails++;
            $display("FAIL wait_valid_timeout: out_valid stayed %b, expected 1", bus.out_valid);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int n0;
        logic [7:0] hold_q, hold_r;
        logic [2*W-1:0] seq [3];

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Model pins.
        check("pin_bcd_14", 32'(to_bcd(14)), 32'h14);
        check("pin_bcd_15", 32'(to_bcd(15)), 32'h15);
        check("pin_bcd_0",  32'(to_bcd(0)),  32'(lit(8'h00, 8'hF0)));
        check("pin_bcd_5",  32'(to_bcd(5)),  32'(lit(8'h05, 8'hF5)));

        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_q_bcd",     32'(bus.q_bcd),     32'h0);
        check("rst_r_bcd",     32'(bus.r_bcd),     32'h0);

        // 100/7 -> q=14 r=2, latency from the accepting edge.
        bus.out_ready = 1'b1;
        send(8'hE2);
        wait_valid(c);
        check("latency_edges", 32'(c), 32'(LAT));
        check("e2_q", 32'(bus.q_bcd), 32'(lit(8'h14, 8'h14)));
        check("e2_r", 32'(bus.r_bcd), 32'(lit(8'h02, 8'hF2)));
        check("e2_done_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        check("e2_idle_in_ready",  32'(bus.in_ready),  32'd1);
        check("e2_idle_out_valid", 32'(bus.out_valid), 32'd0);

        // Back-to-back with in_valid held high.
        res_q.delete();
        seq[0] = 8'hD5;
        seq[1] = 8'hFF;
        seq[2] = 8'h00;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            int t;
            t = 0;
            bus.in_data = seq[k];
            while (bus.in_ready !== 1'b1 && t < 60) begin
                tick();
                t++;
            end
            if (t >= 60) begin
                n_checks++;
                n_fails++;
                $display("FAIL b2b_timeout: in_ready stayed %b, expected 1", bus.in_ready);
            end
            tick();
        end
        bus.in_valid = 1'b0;
        c = 0;
        while (res_q.size() < 3 && c < 60) begin
            tick();
            c++;
        end
        check("b2b_count", 32'(res_q.size()), 32'd3);
        if (res_q.size() >= 3) begin
            check("b2b_0", 32'(res_q[0]), 32'({lit(8'h13, 8'h13), lit(8'h05, 8'hF5)}));
            check("b2b_1", 32'(res_q[1]), 32'({lit(8'h15, 8'h15), lit(8'h15, 8'h15)}));
            check("b2b_2", 32'(res_q[2]), 32'({lit(8'h00, 8'hF0), lit(8'h00, 8'hF0)}));
        end
        tick();

        // Backpressure for 20 cycles.
        bus.out_ready = 1'b0;
        send(8'h72);
        wait_valid(c);
        hold_q = lit(8'h07, 8'hF7);
        hold_r = lit(8'h02, 8'hF2);
        n0 = res_q.size();
        for (int k = 0; k < 20; k++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data  = 8'($urandom);
            tick();
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready",  32'(bus.in_ready),  32'd0);
            check("bp_q", 32'(bus.q_bcd), 32'(hold_q));
            check("bp_r", 32'(bus.r_bcd), 32'(hold_r));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
        check("bp_release_in_ready",  32'(bus.in_ready),  32'd1);
        check("bp_handshakes", 32'(res_q.size() - n0), 32'd1);

        // Reset in the 6th conversion cycle.
        send(8'h9C);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_q", 32'(bus.q_bcd), 32'h0);
        check("midrst_r", 32'(bus.r_bcd), 32'h0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        send(8'h31);
        wait_valid(c);
        check("x31_q", 32'(bus.q_bcd), 32'(lit(8'h03, 8'hF3)));
        check("x31_r", 32'(bus.r_bcd), 32'(lit(8'h01, 8'hF1)));
        tick();

        // Input noise during conversion.
        send(8'hA3);
        for (int k = 0; k < LAT - 1; k++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data  = 8'($urandom);
            tick();
        end
        bus.in_valid = 1'b0;
        wait_valid(c);
        check("noise_q", 32'(bus.q_bcd), 32'(lit(8'h10, 8'h10)));
        check("noise_r", 32'(bus.r_bcd), 32'(lit(8'h03, 8'hF3)));
        tick();

        // Blanking case (plain in the default build).
        send(8'h50);
        wait_valid(c);
        check("x50_q", 32'(bus.q_bcd), 32'(lit(8'h05, 8'hF5)));
        check("x50_r", 32'(bus.r_bcd), 32'(lit(8'h00, 8'hF0)));
        tick();

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            bus.in_valid  = ($urandom_range(0, 99) < 50);
            bus.in_data   = 8'($urandom);
            bus.out_ready = ($urandom_range(0, 99) < 70);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2 * LAT + 4) tick();
        check("final_idle", 32'(bus.in_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
